// File: rtl/sparse_dot_engine_if.sv
// Handshake bundle for sparse_dot_engine.
//   master : vector producer / result consumer (drives in_*, act_vec,
//            wgt_vec, relu_en, out_ready)
//   slave  : the engine (drives in_ready, out_valid, out_data, out_sat,
//            out_nnz)
// Channel k of act_vec sits at [k*AW +: AW], of wgt_vec at [k*WW +: WW].
interface sparse_dot_engine_if #(
  parameter int N  = 8,
  parameter int AW = 9,
  parameter int WW = 2,
  parameter int OW = 12
);
  localparam int NNW = $clog2(N + 1);

  logic              in_valid;
  logic              in_ready;
  logic [N*AW-1:0]   act_vec;
  logic [N*WW-1:0]   wgt_vec;
  logic              relu_en;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic              out_sat;
  logic [NNW-1:0]    out_nnz;

  modport master (
    output in_valid, act_vec, wgt_vec, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_nnz
  );

  modport slave (
    input  in_valid, act_vec, wgt_vec, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_nnz
  );
endinterface

// File: rtl/sparse_dot_engine.sv
// Sparse dot-product neuron. Accepts an N-channel activation vector and
// signed weight vector, then multiply-accumulates only the channels where
// both operands are nonzero, one pair per clock, lowest channel first.
// Result leaves via valid/ready with optional ReLU, saturation to OW bits
// and a count of MACs performed.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : sparse_dot_engine_if.slave (input vector + result handshake)

// Per-channel pair detect and full-precision product.
module sparse_dot_lane #(
  parameter int AW = 9,
  parameter int WW = 2
) (
  input  logic [AW-1:0]    act,
  input  logic [WW-1:0]    wgt,
  output logic             pair_nz,
  output logic [AW+WW-1:0] prod
);
  logic signed [AW+WW-1:0] act_x, wgt_x;

  assign act_x   = {{WW{act[AW-1]}}, act};
  assign wgt_x   = {{AW{wgt[WW-1]}}, wgt};
  assign prod    = act_x * wgt_x;
  assign pair_nz = (act != '0) && (wgt != '0);
endmodule

module sparse_dot_engine #(
  parameter int N  = 8,
  parameter int AW = 9,
  parameter int WW = 2,
  parameter int OW = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  sparse_dot_engine_if.slave   bus
);
  localparam int CW  = AW + WW + $clog2(N);
  localparam int PW  = AW + WW;
  localparam int SW  = $clog2(N);
  localparam int NNW = $clog2(N + 1);
  // Saturation compare runs wide enough to hold both acc and out range.
  localparam int XW  = (CW > OW) ? CW : OW;
  localparam logic signed [XW-1:0] SAT_HI = XW'((2 ** (OW - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, INDEX, MAC, DONE} state_t;
  state_t state;

  logic [N*AW-1:0]       act_q;
  logic [N*WW-1:0]       wgt_q;
  logic                  relu_q;
  logic [N-1:0]          pending;
  logic [N-1:0]          pending_nxt;
  logic signed [CW-1:0]  acc;
  logic signed [CW-1:0]  acc_nxt;
  logic [NNW-1:0]        nnz;
  logic [N-1:0]          pair_nz;
  logic [N-1:0][PW-1:0]  prods;
  logic [SW-1:0]         sel;
  logic signed [XW-1:0]  vx;
  logic [OW-1:0]         res_data;
  logic                  res_sat;

  logic                  out_valid_q, out_sat_q;
  logic [OW-1:0]         out_data_q;
  logic [NNW-1:0]        out_nnz_q;

  for (genvar k = 0; k < N; k++) begin : g_lane
    sparse_dot_lane #(.AW(AW), .WW(WW)) u_lane (
      .act     (act_q[k*AW +: AW]),
      .wgt     (wgt_q[k*WW +: WW]),
      .pair_nz (pair_nz[k]),
      .prod    (prods[k])
    );
  end

  // Lowest pending channel wins; scanning downward leaves the lowest set.
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--)
      if (pending[k]) sel = SW'(k);
    pending_nxt = pending & (pending - 1'b1);
    acc_nxt     = acc + CW'($signed(prods[sel]));
    vx          = XW'(acc_nxt);
    if (relu_q && vx < 0) vx = '0;
    res_sat  = 1'b0;
    res_data = vx[OW-1:0];
    if (vx > SAT_HI) begin
      res_data = SAT_HI[OW-1:0];
      res_sat  = 1'b1;
    end else if (vx < SAT_LO) begin
      res_data = SAT_LO[OW-1:0];
      res_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      act_q       <= '0;
      wgt_q       <= '0;
      relu_q      <= 1'b0;
      pending     <= '0;
      acc         <= '0;
      nnz         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_nnz_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          act_q  <= bus.act_vec;
          wgt_q  <= bus.wgt_vec;
          relu_q <= bus.relu_en;
          state  <= INDEX;
        end
        INDEX: begin
          acc     <= '0;
          nnz     <= '0;
          pending <= pair_nz;
          if (pair_nz == '0) begin
            // Empty intersection: result is zero regardless of ReLU.
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_nnz_q   <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            state <= MAC;
          end
        end
        MAC: begin
          acc     <= acc_nxt;
          nnz     <= nnz + 1'b1;
          pending <= pending_nxt;
          if (pending_nxt == '0) begin
            out_data_q  <= res_data;
            out_sat_q   <= res_sat;
            out_nnz_q   <= nnz + 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_nnz   = out_nnz_q;
endmodule

// File: tb/tb_sparse_dot_engine.sv
module tb_sparse_dot_engine;
  localparam int N  = 8;
  localparam int AW = 9;
  localparam int WW = 2;
  localparam int OW = 12;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   av[8];
  int   wv[8];

  sparse_dot_engine_if #(.N(N), .AW(AW), .WW(WW), .OW(OW)) bus ();

  sparse_dot_engine #(.N(N), .AW(AW), .WW(WW), .OW(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic load_vec(input logic relu);
    for (int k = 0; k < N; k++) begin
      bus.act_vec[k*AW +: AW] = AW'(av[k]);
      bus.wgt_vec[k*WW +: WW] = WW'(wv[k]);
    end
    bus.relu_en = relu;
  endtask

  // Called on the negedge right after the accepting edge; lat counts edges.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int e_data,
                              input int e_nnz, input int e_sat);
    check({tag, "_data"}, int'($signed(bus.out_data)), e_data);
    check({tag, "_nnz"},  int'(bus.out_nnz), e_nnz);
    check({tag, "_sat"},  int'(bus.out_sat), e_sat);
  endtask

  task automatic run_vec(input string tag, input logic relu, input int e_data,
                         input int e_nnz, input int e_sat, input int e_lat);
    int lat;
    int w;
    @(negedge clk);
    load_vec(relu);
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(lat);
    check({tag, "_lat"}, lat, e_lat);
    check_result(tag, e_data, e_nnz, e_sat);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_vld_clr"}, int'(bus.out_valid), 0);
    check({tag, "_rdy_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int lat;
    int seen;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.act_vec   = '0;
    bus.wgt_vec   = '0;
    bus.relu_en   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data",  int'(bus.out_data), 0);
    check("rst_out_sat",   int'(bus.out_sat), 0);
    check("rst_out_nnz",   int'(bus.out_nnz), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(bus.in_ready), 1);

    // out_ready while idle is harmless
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_ready_noeff", int'(bus.out_valid), 0);

    // Basic mixed vector: 1-3+4-6+7+8 = 11
    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    wv = '{1, 0, -1, 1, 0, -1, 1, 1};
    run_vec("basic", 1'b0, 11, 6, 0, 7);

    // All-zero weights
    av = '{5, 5, 5, 5, 5, 5, 5, 5};
    wv = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_vec("zero_w", 1'b0, 0, 0, 0, 1);

    // Single nonzero pair in the top channel
    av = '{0, 0, 0, 0, 0, 0, 0, 1};
    wv = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_vec("single", 1'b0, 1, 1, 0, 2);

    // Positive saturation: 8 * 512 = 4096
    av = '{-256, -256, -256, -256, -256, -256, -256, -256};
    wv = '{-2, -2, -2, -2, -2, -2, -2, -2};
    run_vec("sat_pos", 1'b0, 2047, 8, 1, 9);

    // Negative saturation: 8 * -510 = -4080
    av = '{255, 255, 255, 255, 255, 255, 255, 255};
    run_vec("sat_neg", 1'b0, -2048, 8, 1, 9);

    // Negated weights, without and with ReLU
    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    wv = '{-1, 0, 1, -1, 0, 1, -1, -1};
    run_vec("neg_norelu", 1'b0, -11, 6, 0, 7);
    run_vec("neg_relu",   1'b1, 0, 6, 0, 7);

    // Backpressure with a second vector queued behind the first
    wv = '{1, 0, -1, 1, 0, -1, 1, 1};
    @(negedge clk);
    load_vec(1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    wv = '{1, 1, 1, 1, 1, 1, 1, 1};
    load_vec(1'b0);
    wait_out(lat);
    check("bp_lat", lat, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", int'(bus.out_valid), 1);
      check("bp_hold_data",  int'($signed(bus.out_data)), 11);
      check("bp_hold_nnz",   int'(bus.out_nnz), 6);
      check("bp_hold_rdy",   int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_hs_vld",  int'(bus.out_valid), 0);
    check("bp_hs_rdy",  int'(bus.in_ready), 1);
    @(negedge clk);
    check("bp_q_taken", int'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("bp_q_lat", lat, 9);
    check_result("bp_q", 36, 8, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset during the third MAC cycle
    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    wv = '{1, 0, -1, 1, 0, -1, 1, 1};
    @(negedge clk);
    load_vec(1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rdy", int'(bus.in_ready), 0);
    check("mid_rst_vld", int'(bus.out_valid), 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_rdy_back", int'(bus.in_ready), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("mid_rst_no_vld", seen, 0);
    av = '{0, 0, 0, 0, 0, 0, 0, 1};
    wv = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_vec("after_rst", 1'b0, 1, 1, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
